// File: rtl/memory_access_stage_pkg.sv
// Shared field positions, FSM encoding and byte-lane constants for the MEM stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package memory_access_stage_pkg;

  // writeBack control bits (Execute uses the same layout)
  localparam int WB_REG_WRITE  = 1;
  localparam int WB_MEM_TO_REG = 0;

  // memAccess control bits
  localparam int ACC_READ  = 2;
  localparam int ACC_WRITE = 1;
  localparam int ACC_BYTE  = 0;

  // byte-lane constants
  localparam logic [3:0] BE_WORD  = 4'b1111;
  localparam logic [3:0] BE_LANE0 = 4'b0001;
  localparam int         CNT_W    = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } memState_t;

  // One-hot lane enable for a byte access at the given address offset.
  function automatic logic [3:0] laneMask(input logic [1:0] lane);
    return BE_LANE0 << lane;
  endfunction

endpackage

// File: rtl/memory_access_stage_byte_lane_unit.sv
// Byte-lane steering: lane enables, replicated store data, extracted/extended load data.
// Latency: purely combinational.
// Backpressure: none; follows its inputs.
module memory_access_stage_byte_lane_unit
  import memory_access_stage_pkg::*;
#(
  parameter int SIGNED_BYTE_LOAD = 0
) (
  input  logic [1:0]  laneSel,
  input  logic        isByte,
  input  logic [31:0] storeIn,
  input  logic [31:0] loadIn,
  output logic [3:0]  byteEnable,
  output logic [31:0] storeOut,
  output logic [31:0] loadOut
);

  logic [7:0] loadByte;

  // Word accesses pass straight through; byte accesses select/replicate one lane.
  always_comb begin
    byteEnable = isByte ? laneMask(laneSel) : BE_WORD;
    storeOut   = isByte ? {4{storeIn[7:0]}} : storeIn;
    loadByte   = loadIn[{laneSel, 3'b000} +: 8];
    if (!isByte) begin
      loadOut = loadIn;
    end else if (SIGNED_BYTE_LOAD != 0) begin
      loadOut = {{24{loadByte[7]}}, loadByte};
    end else begin
      loadOut = {24'h000000, loadByte};
    end
  end

endmodule

// File: rtl/memory_access_stage.sv
// MEM pipeline stage: word/byte loads and stores over a req/ack bus, registered MEM/WB outputs.
// Latency: 1 cycle for non-memory ops, >=2 cycles for memory ops (IDLE->ACCESS->complete).
// Backpressure: stall holds EX/MEM upstream from op acceptance until ack or ack timeout.
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int TIMEOUT          = 16,
  parameter int SIGNED_BYTE_LOAD = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  exMemWriteBack,
  input  logic [2:0]  exMemAccess,
  input  logic [31:0] exMemResult,
  input  logic [31:0] exMemWriteData,
  input  logic [4:0]  exMemRd,
  output logic [31:0] memAddr,
  output logic [31:0] memWriteData,
  output logic [3:0]  memByteEnable,
  output logic        memWe,
  output logic        memReq,
  input  logic [31:0] memReadData,
  input  logic        memAck,
  output logic        stall,
  output logic        memWbRegWrite,
  output logic [4:0]  memWbRd,
  output logic [31:0] memWbData,
  output logic        busError,
  output logic [31:0] busErrorAddr
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT - 1);

  memState_t        state;
  logic [CNT_W-1:0] counter;

  logic        isRead;
  logic        isWrite;
  logic        isByte;
  logic        isOp;
  logic        isIllegal;
  logic        isMisaligned;
  logic        isFault;
  logic        isValidOp;
  logic        lastCycle;
  logic [31:0] loadData;

  assign isRead       = exMemAccess[ACC_READ];
  assign isWrite      = exMemAccess[ACC_WRITE];
  assign isByte       = exMemAccess[ACC_BYTE];
  assign isOp         = isRead ^ isWrite;
  assign isIllegal    = isRead & isWrite;
  assign isMisaligned = isOp & ~isByte & (exMemResult[1:0] != 2'b00);
  assign isFault      = isIllegal | isMisaligned;
  assign isValidOp    = isOp & ~isMisaligned;
  assign lastCycle    = (counter == LAST_COUNT);

  // EX/MEM inputs are held by stall, so the bus side is driven straight from them.
  assign memAddr = {exMemResult[31:2], 2'b00};

  memory_access_stage_byte_lane_unit #(
    .SIGNED_BYTE_LOAD(SIGNED_BYTE_LOAD)
  ) u_laneUnit (
    .laneSel   (exMemResult[1:0]),
    .isByte    (isByte),
    .storeIn   (exMemWriteData),
    .loadIn    (memReadData),
    .byteEnable(memByteEnable),
    .storeOut  (memWriteData),
    .loadOut   (loadData)
  );

  // Request and stall; gated by reset so they drop the moment reset rises.
  always_comb begin
    memReq = 1'b0;
    memWe  = 1'b0;
    stall  = 1'b0;
    if (!reset) begin
      if (state == ACCESS) begin
        memReq = 1'b1;
        memWe  = isWrite;
        stall  = ~(memAck | lastCycle);
      end else begin
        stall = isValidOp;
      end
    end
  end

  // FSM, timeout counter, MEM/WB register and sticky bus-error capture.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      counter       <= '0;
      memWbRegWrite <= 1'b0;
      memWbRd       <= '0;
      memWbData     <= '0;
      busError      <= 1'b0;
      busErrorAddr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          memWbRd <= exMemRd;
          if (isFault) begin
            memWbRegWrite <= 1'b0;
            memWbData     <= '0;
            busError      <= 1'b1;
            if (!busError) busErrorAddr <= exMemResult;
          end else if (isValidOp) begin
            // Bubble while the access is in flight; the real result lands on completion.
            state         <= ACCESS;
            counter       <= '0;
            memWbRegWrite <= 1'b0;
            memWbData     <= '0;
          end else begin
            memWbRegWrite <= exMemWriteBack[WB_REG_WRITE];
            memWbData     <= exMemResult;
          end
        end
        ACCESS: begin
          if (memAck) begin
            state         <= IDLE;
            memWbRegWrite <= exMemWriteBack[WB_REG_WRITE];
            memWbRd       <= exMemRd;
            memWbData     <= (isRead & exMemWriteBack[WB_MEM_TO_REG]) ? loadData : exMemResult;
          end else if (lastCycle) begin
            state         <= IDLE;
            memWbRegWrite <= 1'b0;
            memWbRd       <= exMemRd;
            memWbData     <= '0;
            busError      <= 1'b1;
            if (!busError) busErrorAddr <= exMemResult;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: two instances (signed/TIMEOUT=16, unsigned/TIMEOUT=4).
// Latency: n/a.
// Backpressure: n/a.
module tb_memory_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  exMemWriteBack;
  logic [2:0]  exMemAccess;
  logic [31:0] exMemResult;
  logic [31:0] exMemWriteData;
  logic [4:0]  exMemRd;

  logic [31:0] memReadDataA, memReadDataB;
  logic        memAckA, memAckB;
  logic [31:0] memAddrA, memAddrB, memWriteDataA, memWriteDataB;
  logic [3:0]  memByteEnableA, memByteEnableB;
  logic        memWeA, memWeB, memReqA, memReqB, stallA, stallB;
  logic        memWbRegWriteA, memWbRegWriteB, busErrorA, busErrorB;
  logic [4:0]  memWbRdA, memWbRdB;
  logic [31:0] memWbDataA, memWbDataB, busErrorAddrA, busErrorAddrB;

  int testCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  memory_access_stage #(.TIMEOUT(16), .SIGNED_BYTE_LOAD(1)) dutA (
    .clk(clk), .reset(reset),
    .exMemWriteBack(exMemWriteBack), .exMemAccess(exMemAccess), .exMemResult(exMemResult),
    .exMemWriteData(exMemWriteData), .exMemRd(exMemRd),
    .memAddr(memAddrA), .memWriteData(memWriteDataA), .memByteEnable(memByteEnableA),
    .memWe(memWeA), .memReq(memReqA), .memReadData(memReadDataA), .memAck(memAckA),
    .stall(stallA), .memWbRegWrite(memWbRegWriteA), .memWbRd(memWbRdA), .memWbData(memWbDataA),
    .busError(busErrorA), .busErrorAddr(busErrorAddrA)
  );

  memory_access_stage #(.TIMEOUT(4), .SIGNED_BYTE_LOAD(0)) dutB (
    .clk(clk), .reset(reset),
    .exMemWriteBack(exMemWriteBack), .exMemAccess(exMemAccess), .exMemResult(exMemResult),
    .exMemWriteData(exMemWriteData), .exMemRd(exMemRd),
    .memAddr(memAddrB), .memWriteData(memWriteDataB), .memByteEnable(memByteEnableB),
    .memWe(memWeB), .memReq(memReqB), .memReadData(memReadDataB), .memAck(memAckB),
    .stall(stallB), .memWbRegWrite(memWbRegWriteB), .memWbRd(memWbRdB), .memWbData(memWbDataB),
    .busError(busErrorB), .busErrorAddr(busErrorAddrB)
  );

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic setOp(input logic [2:0] acc, input logic [1:0] wb, input logic [31:0] res,
                       input logic [31:0] wd, input logic [4:0] rd);
    exMemAccess    = acc;
    exMemWriteBack = wb;
    exMemResult    = res;
    exMemWriteData = wd;
    exMemRd        = rd;
  endtask

  // State changes on negedge: combinational outputs are sampled just after posedge,
  // registered outputs just after negedge.
  task automatic midCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic endCycle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    setOp(3'b000, 2'b00, 32'h0, 32'h0, 5'd0);
    memAckA = 1'b0; memAckB = 1'b0;
    memReadDataA = 32'h0; memReadDataB = 32'h0;
    endCycle();
    endCycle();

    // reset state
    checkValue("rst memReqA", memReqA, 32'h0);
    checkValue("rst stallA", stallA, 32'h0);
    checkValue("rst memWbRegWriteA", memWbRegWriteA, 32'h0);
    checkValue("rst memWbDataB", memWbDataB, 32'h0);
    checkValue("rst busErrorB", busErrorB, 32'h0);
    reset = 1'b0;

    // pass-through
    setOp(3'b000, 2'b10, 32'h1234, 32'h0, 5'd7);
    midCycle();
    checkValue("pt stallA", stallA, 32'h0);
    checkValue("pt memReqA", memReqA, 32'h0);
    checkValue("pt memReqB", memReqB, 32'h0);
    endCycle();
    checkValue("pt memWbRegWriteA", memWbRegWriteA, 32'h1);
    checkValue("pt memWbRdA", memWbRdA, 32'd7);
    checkValue("pt memWbDataA", memWbDataA, 32'h1234);
    checkValue("pt memWbDataB", memWbDataB, 32'h1234);

    // word load, ack arrives on the fourth ACCESS cycle
    setOp(3'b100, 2'b11, 32'h100, 32'h0, 5'd3);
    memReadDataA = 32'hDEADBEEF; memReadDataB = 32'hDEADBEEF;
    for (int c = 0; c < 4; c++) begin
      midCycle();
      checkValue("wl stallA", stallA, 32'h1);
      checkValue("wl stallB", stallB, 32'h1);
      checkValue("wl memReqA", memReqA, (c == 0) ? 32'h0 : 32'h1);
      if (c > 0) begin
        checkValue("wl memAddrA", memAddrA, 32'h100);
        checkValue("wl memByteEnableA", memByteEnableA, 32'hF);
        checkValue("wl memWeA", memWeA, 32'h0);
      end
      endCycle();
      if (c == 0) checkValue("wl bubbleA", memWbRegWriteA, 32'h0);
    end
    memAckA = 1'b1; memAckB = 1'b1;
    midCycle();
    checkValue("wl ack stallA", stallA, 32'h0);
    checkValue("wl ack stallB", stallB, 32'h0);
    endCycle();
    memAckA = 1'b0; memAckB = 1'b0;
    checkValue("wl memWbDataA", memWbDataA, 32'hDEADBEEF);
    checkValue("wl memWbRegWriteA", memWbRegWriteA, 32'h1);
    checkValue("wl memWbRdA", memWbRdA, 32'd3);
    checkValue("wl memWbDataB", memWbDataB, 32'hDEADBEEF);
    checkValue("wl busErrorB", busErrorB, 32'h0);

    // byte store, one-cycle ack
    setOp(3'b011, 2'b10, 32'h203, 32'h000000AB, 5'd4);
    midCycle();
    checkValue("bs stallA", stallA, 32'h1);
    checkValue("bs idle memReqA", memReqA, 32'h0);
    endCycle();
    memAckA = 1'b1; memAckB = 1'b1;
    midCycle();
    checkValue("bs memReqA", memReqA, 32'h1);
    checkValue("bs memAddrA", memAddrA, 32'h200);
    checkValue("bs memAddrB", memAddrB, 32'h200);
    checkValue("bs memByteEnableA", memByteEnableA, 32'h8);
    checkValue("bs memByteEnableB", memByteEnableB, 32'h8);
    checkValue("bs memWriteDataA", memWriteDataA, 32'hABABABAB);
    checkValue("bs memWriteDataB", memWriteDataB, 32'hABABABAB);
    checkValue("bs memWeA", memWeA, 32'h1);
    checkValue("bs memWeB", memWeB, 32'h1);
    checkValue("bs stallA", stallA, 32'h0);
    endCycle();
    memAckA = 1'b0; memAckB = 1'b0;
    checkValue("bs memWbRegWriteA", memWbRegWriteA, 32'h1);
    checkValue("bs memWbDataA", memWbDataA, 32'h203);
    checkValue("bs memWbRdB", memWbRdB, 32'd4);

    // byte load from lane 1: signed on A, unsigned on B
    setOp(3'b101, 2'b11, 32'h41, 32'h0, 5'd5);
    memReadDataA = 32'h00008000; memReadDataB = 32'h00008000;
    midCycle();
    endCycle();
    memAckA = 1'b1; memAckB = 1'b1;
    midCycle();
    checkValue("bl memByteEnableA", memByteEnableA, 32'h2);
    checkValue("bl memAddrA", memAddrA, 32'h40);
    endCycle();
    memAckA = 1'b0; memAckB = 1'b0;
    checkValue("bl signed memWbDataA", memWbDataA, 32'hFFFFFF80);
    checkValue("bl unsigned memWbDataB", memWbDataB, 32'h00000080);

    // timeout on B (TIMEOUT=4, no ack); A acks on the same cycle B gives up
    setOp(3'b100, 2'b11, 32'h300, 32'h0, 5'd6);
    memReadDataA = 32'h11111111;
    for (int c = 0; c < 4; c++) begin
      midCycle();
      checkValue("to stallB", stallB, 32'h1);
      endCycle();
    end
    memAckA = 1'b1;
    midCycle();
    checkValue("to last stallB", stallB, 32'h0);
    checkValue("to memReqB", memReqB, 32'h1);
    endCycle();
    memAckA = 1'b0;
    checkValue("to memWbRegWriteB", memWbRegWriteB, 32'h0);
    checkValue("to memWbDataB", memWbDataB, 32'h0);
    checkValue("to busErrorB", busErrorB, 32'h1);
    checkValue("to busErrorAddrB", busErrorAddrB, 32'h300);
    checkValue("to memWbRegWriteA", memWbRegWriteA, 32'h1);
    checkValue("to memWbDataA", memWbDataA, 32'h11111111);
    checkValue("to busErrorA", busErrorA, 32'h0);

    // misaligned word: first error for A, later error for B
    setOp(3'b100, 2'b11, 32'h302, 32'h0, 5'd9);
    midCycle();
    checkValue("ma stallA", stallA, 32'h0);
    checkValue("ma stallB", stallB, 32'h0);
    checkValue("ma memReqA", memReqA, 32'h0);
    endCycle();
    checkValue("ma memWbRegWriteB", memWbRegWriteB, 32'h0);
    checkValue("ma memWbRdB", memWbRdB, 32'd9);
    checkValue("ma memWbDataA", memWbDataA, 32'h0);
    checkValue("ma busErrorA", busErrorA, 32'h1);
    checkValue("ma busErrorAddrA", busErrorAddrA, 32'h302);
    checkValue("ma busErrorAddrB", busErrorAddrB, 32'h300);

    // reset in the middle of an access, then the held op restarts
    setOp(3'b010, 2'b00, 32'h400, 32'h55, 5'd10);
    midCycle();
    endCycle();
    midCycle();
    checkValue("rs memReqA", memReqA, 32'h1);
    checkValue("rs memWeA", memWeA, 32'h1);
    reset = 1'b1;
    #1;
    checkValue("rs async memReqA", memReqA, 32'h0);
    checkValue("rs async memWeA", memWeA, 32'h0);
    checkValue("rs async stallA", stallA, 32'h0);
    checkValue("rs async busErrorA", busErrorA, 32'h0);
    checkValue("rs async busErrorAddrB", busErrorAddrB, 32'h0);
    checkValue("rs async memWbRdA", memWbRdA, 32'h0);
    #1;
    reset = 1'b0;
    #1;
    checkValue("rs restart stallA", stallA, 32'h1);
    checkValue("rs restart memReqA", memReqA, 32'h0);
    endCycle();
    memAckA = 1'b1; memAckB = 1'b1;
    midCycle();
    checkValue("rs access memReqA", memReqA, 32'h1);
    endCycle();
    memAckA = 1'b0; memAckB = 1'b0;
    checkValue("rs memWbDataA", memWbDataA, 32'h400);
    checkValue("rs memWbRegWriteA", memWbRegWriteA, 32'h0);

    // ack while idle has no effect on a plain op
    setOp(3'b000, 2'b10, 32'h77, 32'h0, 5'd2);
    memAckA = 1'b1;
    midCycle();
    checkValue("ia memReqA", memReqA, 32'h0);
    endCycle();
    memAckA = 1'b0;
    checkValue("ia memWbDataA", memWbDataA, 32'h77);
    checkValue("ia busErrorA", busErrorA, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
